// File: rtl/wt_dcache_ship_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wt_cache_pkg
// Brief   : Shared types, constants and helpers for the dcache SHiP tracker.
// Revision: 1.0 - initial release
// ============================================================================
package wt_cache_pkg;

  localparam int unsigned SHIP_SIG_WIDTH = 14;

  typedef logic [SHIP_SIG_WIDTH-1:0] ship_sig_t;

  localparam logic [1:0] SHIP_RRPV_DISTANT = 2'd3;
  localparam logic [1:0] SHIP_RRPV_LONG    = 2'd2;

  // Folds two 14-bit PC slices so nearby load sites spread across the SHCT.
  function automatic ship_sig_t ship_sig(input logic [63:0] pc);
    return pc[15:2] ^ pc[29:16];
  endfunction

endpackage
`default_nettype wire

// File: rtl/wt_dcache_ship_tracker_if.sv
`default_nettype none
// ============================================================================
// Module  : wt_dcache_ship_tracker_if
// Brief   : Access/fill event, insertion and predictor-training bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface wt_dcache_ship_tracker_if #(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned NumWays  = 8,
  parameter int unsigned SigWidth = 14
);
  localparam int unsigned c_set_w = $clog2(NumSets);
  localparam int unsigned c_way_w = $clog2(NumWays);

  logic                flush_i;
  logic                acc_valid_i;
  logic                acc_ready_o;
  logic                acc_hit_i;
  logic [c_set_w-1:0]  acc_set_i;
  logic [c_way_w-1:0]  acc_way_i;
  logic                fill_valid_i;
  logic                fill_ready_o;
  logic [c_set_w-1:0]  fill_set_i;
  logic [c_way_w-1:0]  fill_way_i;
  logic [63:0]         fill_pc_i;
  logic                ins_valid_o;
  logic [1:0]          ins_rrpv_o;
  logic                pred_hit_o;
  logic                pred_miss_o;
  logic                pred_outcome_o;
  logic [SigWidth-1:0] pred_hit_shct_o;
  logic [SigWidth-1:0] pred_miss_shct_o;
  logic [SigWidth-1:0] pred_shct_o;
  logic [1:0]          pred_result_i;

  modport master (
    output flush_i, acc_valid_i, acc_hit_i, acc_set_i, acc_way_i,
           fill_valid_i, fill_set_i, fill_way_i, fill_pc_i, pred_result_i,
    input  acc_ready_o, fill_ready_o, ins_valid_o, ins_rrpv_o,
           pred_hit_o, pred_miss_o, pred_outcome_o,
           pred_hit_shct_o, pred_miss_shct_o, pred_shct_o
  );

  modport slave (
    input  flush_i, acc_valid_i, acc_hit_i, acc_set_i, acc_way_i,
           fill_valid_i, fill_set_i, fill_way_i, fill_pc_i, pred_result_i,
    output acc_ready_o, fill_ready_o, ins_valid_o, ins_rrpv_o,
           pred_hit_o, pred_miss_o, pred_outcome_o,
           pred_hit_shct_o, pred_miss_shct_o, pred_shct_o
  );
endinterface
`default_nettype wire

// File: rtl/wt_dcache_ship_tracker_meta.sv
`default_nettype none
// ============================================================================
// Module  : wt_dcache_ship_meta
// Brief   : Per-line valid/signature/outcome flops; one write port, two reads.
// Revision: 1.0 - initial release
// ============================================================================
module wt_dcache_ship_meta #(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned NumWays  = 8,
  parameter int unsigned SigWidth = 14,
  localparam int unsigned c_entries = NumSets * NumWays,
  localparam int unsigned c_idx_w   = $clog2(c_entries)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  // write port: fill installs a line, hit marks it re-referenced
  input  logic                fill_we_i,
  input  logic [c_idx_w-1:0]  fill_idx_i,
  input  logic [SigWidth-1:0] fill_sig_i,
  input  logic                hit_we_i,
  input  logic [c_idx_w-1:0]  hit_idx_i,
  input  logic [c_idx_w-1:0]  acc_idx_i,
  output logic                acc_valid_o,
  output logic [SigWidth-1:0] acc_sig_o,
  input  logic [c_idx_w-1:0]  vic_idx_i,
  output logic                vic_valid_o,
  output logic [SigWidth-1:0] vic_sig_o,
  output logic                vic_outcome_o
);
  logic [c_entries-1:0] r_valid;
  logic [c_entries-1:0] r_outcome;
  logic [SigWidth-1:0]  r_sig [c_entries];

  // A fill to the same line as a concurrent hit wins: the new line starts cold.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid   <= '0;
      r_outcome <= '0;
    end else begin
      if (hit_we_i) r_outcome[hit_idx_i] <= 1'b1;
      if (fill_we_i) begin
        r_valid[fill_idx_i]   <= 1'b1;
        r_outcome[fill_idx_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) r_sig[fill_idx_i] <= fill_sig_i;
  end

  assign acc_valid_o   = r_valid[acc_idx_i];
  assign acc_sig_o     = r_sig[acc_idx_i];
  assign vic_valid_o   = r_valid[vic_idx_i];
  assign vic_sig_o     = r_sig[vic_idx_i];
  assign vic_outcome_o = r_outcome[vic_idx_i];
endmodule
`default_nettype wire

// File: rtl/wt_dcache_ship_tracker.sv
`default_nettype none
// ============================================================================
// Module  : wt_dcache_ship_tracker
// Brief   : SHiP signature/outcome tracker producing SHCT training pulses.
// Revision: 1.0 - initial release
// ============================================================================
module wt_dcache_ship_tracker
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned NumWays  = 8,
  parameter int unsigned SigWidth = 14
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  wt_dcache_ship_tracker_if.slave       bus
);
  localparam int unsigned c_idx_w = $clog2(NumSets * NumWays);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_evict  = 2'd1;
  localparam logic [1:0] c_st_insert = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [c_idx_w-1:0]  r_fill_idx;
  logic [SigWidth-1:0] r_new_sig;
  logic [1:0]          r_result;
  logic                r_hit_vld, r_skid_vld;
  logic [SigWidth-1:0] r_hit_sig, r_skid_sig;

  logic [c_idx_w-1:0]  w_acc_idx;
  logic                w_acc_line_vld, w_vic_vld, w_vic_outcome;
  logic [SigWidth-1:0] w_acc_sig, w_vic_sig;
  logic                w_acc_fire, w_hit_acc, w_fill_fire, w_ins, w_miss, w_fwd;
  logic                w_cand_vld, w_defer, w_pred_hit;
  logic [SigWidth-1:0] w_cand_sig;

  assign w_acc_idx   = {bus.acc_set_i, bus.acc_way_i};
  assign w_acc_fire  = bus.acc_valid_i & bus.acc_ready_o;
  assign w_hit_acc   = w_acc_fire & bus.acc_hit_i & w_acc_line_vld;
  assign w_fill_fire = bus.fill_valid_i & bus.fill_ready_o;
  assign w_ins       = (r_state == c_st_insert) & ~bus.flush_i;
  assign w_miss      = (r_state == c_st_evict) & ~bus.flush_i & w_vic_vld;
  assign w_fwd       = w_hit_acc & (w_acc_idx == r_fill_idx);

  // Skid entry is issued ahead of a freshly registered hit.
  assign w_cand_vld  = ~bus.flush_i & (r_skid_vld | r_hit_vld);
  assign w_cand_sig  = r_skid_vld ? r_skid_sig : r_hit_sig;
  assign w_defer     = w_cand_vld & w_miss & (w_cand_sig == w_vic_sig);
  assign w_pred_hit  = w_cand_vld & ~w_defer;

  wt_dcache_ship_meta #(
    .NumSets  (NumSets),
    .NumWays  (NumWays),
    .SigWidth (SigWidth)
  ) u_meta (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (bus.flush_i),
    .fill_we_i     (w_ins),
    .fill_idx_i    (r_fill_idx),
    .fill_sig_i    (r_new_sig),
    .hit_we_i      (w_hit_acc),
    .hit_idx_i     (w_acc_idx),
    .acc_idx_i     (w_acc_idx),
    .acc_valid_o   (w_acc_line_vld),
    .acc_sig_o     (w_acc_sig),
    .vic_idx_i     (r_fill_idx),
    .vic_valid_o   (w_vic_vld),
    .vic_sig_o     (w_vic_sig),
    .vic_outcome_o (w_vic_outcome)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_fill_fire) w_state_nxt = c_st_evict;
      c_st_evict:  w_state_nxt = c_st_insert;
      c_st_insert: w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
    if (bus.flush_i) w_state_nxt = c_st_idle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= c_st_idle;
      r_fill_idx <= '0;
      r_new_sig  <= '0;
      r_result   <= '0;
      r_hit_vld  <= 1'b0;
      r_hit_sig  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_sig <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill_fire) begin
        r_fill_idx <= {bus.fill_set_i, bus.fill_way_i};
        r_new_sig  <= SigWidth'(ship_sig(bus.fill_pc_i));
      end
      if (r_state == c_st_evict) r_result <= bus.pred_result_i;

      if (bus.flush_i) begin
        r_hit_vld <= 1'b0;
      end else if (w_hit_acc) begin
        r_hit_vld <= 1'b1;
        r_hit_sig <= w_acc_sig;
      end else if (r_hit_vld && !r_skid_vld && (w_pred_hit || w_defer)) begin
        r_hit_vld <= 1'b0;
      end

      if (bus.flush_i) begin
        r_skid_vld <= 1'b0;
      end else if (w_defer && !r_skid_vld) begin
        r_skid_vld <= 1'b1;
        r_skid_sig <= r_hit_sig;
      end else if (r_skid_vld && w_pred_hit) begin
        r_skid_vld <= 1'b0;
      end
    end
  end

  assign bus.acc_ready_o  = ~r_skid_vld & ~bus.flush_i;
  assign bus.fill_ready_o = (r_state == c_st_idle) & ~bus.flush_i;
  assign bus.ins_valid_o  = w_ins;
  assign bus.ins_rrpv_o   = !w_ins ? 2'd0 :
                            (r_result == 2'd0) ? SHIP_RRPV_DISTANT : SHIP_RRPV_LONG;

  assign bus.pred_hit_o     = w_pred_hit;
  assign bus.pred_miss_o    = w_miss;
  assign bus.pred_outcome_o = w_miss & (w_vic_outcome | w_fwd);
  assign bus.pred_shct_o    = r_new_sig;

  // Idle index of each port is the other's index with bit 0 flipped so the
  // SHCT never rewrites the entry being trained on the active port.
  assign bus.pred_hit_shct_o  = w_pred_hit ? w_cand_sig :
                                w_miss     ? (w_vic_sig ^ SigWidth'(1)) : '0;
  assign bus.pred_miss_shct_o = w_miss ? w_vic_sig : (bus.pred_hit_shct_o ^ SigWidth'(1));
endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_ship_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_wt_dcache_ship_tracker
// Brief   : Directed self-checking bench for the SHiP tracker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wt_dcache_ship_tracker;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wt_dcache_ship_tracker_if #(.NumSets(256), .NumWays(8), .SigWidth(14)) bus ();

  wt_dcache_ship_tracker #(.NumSets(256), .NumWays(8), .SigWidth(14)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.flush_i      = 1'b0;
    bus.acc_valid_i  = 1'b0;
    bus.acc_hit_i    = 1'b0;
    bus.acc_set_i    = '0;
    bus.acc_way_i    = '0;
    bus.fill_valid_i = 1'b0;
    bus.fill_set_i   = '0;
    bus.fill_way_i   = '0;
    bus.fill_pc_i    = '0;
  endtask

  task automatic start_fill(input int set, input int way, input logic [63:0] pc);
    bus.fill_valid_i = 1'b1;
    bus.fill_set_i   = 8'(set);
    bus.fill_way_i   = 3'(way);
    bus.fill_pc_i    = pc;
  endtask

  task automatic start_hit(input int set, input int way);
    bus.acc_valid_i = 1'b1;
    bus.acc_hit_i   = 1'b1;
    bus.acc_set_i   = 8'(set);
    bus.acc_way_i   = 3'(way);
  endtask

  // Complete fill sequence, returning in the IDLE cycle that follows INSERT.
  task automatic do_fill(input int set, input int way, input logic [63:0] pc);
    @(negedge clk); start_fill(set, way, pc);
    @(negedge clk); drive_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.pred_result_i = 2'd0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin failures++; $display("FAIL reset_pred_hit got=%b exp=0", bus.pred_hit_o); end
    checks++; if (bus.pred_miss_o !== 1'b0) begin failures++; $display("FAIL reset_pred_miss got=%b exp=0", bus.pred_miss_o); end
    checks++; if (bus.pred_outcome_o !== 1'b0) begin failures++; $display("FAIL reset_pred_outcome got=%b exp=0", bus.pred_outcome_o); end
    checks++; if (bus.ins_valid_o !== 1'b0) begin failures++; $display("FAIL reset_ins_valid got=%b exp=0", bus.ins_valid_o); end
    checks++; if (bus.ins_rrpv_o !== 2'd0) begin failures++; $display("FAIL reset_ins_rrpv got=%0d exp=0", bus.ins_rrpv_o); end
    checks++; if (bus.pred_shct_o !== 14'h0) begin failures++; $display("FAIL reset_pred_shct got=%h exp=0000", bus.pred_shct_o); end
    checks++; if (bus.fill_ready_o !== 1'b1) begin failures++; $display("FAIL reset_fill_ready got=%b exp=1", bus.fill_ready_o); end
    checks++; if (bus.acc_ready_o !== 1'b1) begin failures++; $display("FAIL reset_acc_ready got=%b exp=1", bus.acc_ready_o); end
    rst = 1'b0;
  endtask

  task automatic test_first_fill();
    @(negedge clk); start_fill(5, 2, 64'h0000_1234); bus.pred_result_i = 2'd0;
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_miss_o !== 1'b0) begin failures++; $display("FAIL first_fill_no_miss got=%b exp=0", bus.pred_miss_o); end
    checks++; if (bus.pred_shct_o !== 14'h048D) begin failures++; $display("FAIL first_fill_pred_shct got=%h exp=048d", bus.pred_shct_o); end
    checks++; if (bus.ins_valid_o !== 1'b0) begin failures++; $display("FAIL first_fill_early_ins got=%b exp=0", bus.ins_valid_o); end
    @(negedge clk); #1;
    checks++; if (bus.ins_valid_o !== 1'b1) begin failures++; $display("FAIL first_fill_ins_valid got=%b exp=1", bus.ins_valid_o); end
    checks++; if (bus.ins_rrpv_o !== 2'd3) begin failures++; $display("FAIL first_fill_rrpv got=%0d exp=3", bus.ins_rrpv_o); end
    checks++; if (bus.fill_ready_o !== 1'b0) begin failures++; $display("FAIL first_fill_busy got=%b exp=0", bus.fill_ready_o); end
    @(negedge clk); #1;
    checks++; if (bus.ins_valid_o !== 1'b0) begin failures++; $display("FAIL first_fill_ins_one_cycle got=%b exp=0", bus.ins_valid_o); end
    checks++; if (bus.fill_ready_o !== 1'b1) begin failures++; $display("FAIL first_fill_ready_again got=%b exp=1", bus.fill_ready_o); end
  endtask

  task automatic test_hit();
    start_hit(5, 2);
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_hit_o !== 1'b1) begin failures++; $display("FAIL hit_pulse got=%b exp=1", bus.pred_hit_o); end
    checks++; if (bus.pred_hit_shct_o !== 14'h048D) begin failures++; $display("FAIL hit_shct got=%h exp=048d", bus.pred_hit_shct_o); end
    checks++; if (bus.pred_miss_shct_o !== 14'h048C) begin failures++; $display("FAIL hit_alias_miss_shct got=%h exp=048c", bus.pred_miss_shct_o); end
    checks++; if (bus.pred_miss_o !== 1'b0) begin failures++; $display("FAIL hit_no_miss got=%b exp=0", bus.pred_miss_o); end
    @(negedge clk); #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b exp=0", bus.pred_hit_o); end
  endtask

  task automatic test_refill();
    start_fill(5, 2, 64'h0001_0000); bus.pred_result_i = 2'd2;
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_miss_o !== 1'b1) begin failures++; $display("FAIL refill_miss got=%b exp=1", bus.pred_miss_o); end
    checks++; if (bus.pred_outcome_o !== 1'b1) begin failures++; $display("FAIL refill_outcome got=%b exp=1", bus.pred_outcome_o); end
    checks++; if (bus.pred_miss_shct_o !== 14'h048D) begin failures++; $display("FAIL refill_miss_shct got=%h exp=048d", bus.pred_miss_shct_o); end
    checks++; if (bus.pred_hit_shct_o !== 14'h048C) begin failures++; $display("FAIL refill_alias_hit_shct got=%h exp=048c", bus.pred_hit_shct_o); end
    checks++; if (bus.pred_shct_o !== 14'h0001) begin failures++; $display("FAIL refill_new_sig got=%h exp=0001", bus.pred_shct_o); end
    @(negedge clk); #1;
    checks++; if (bus.ins_rrpv_o !== 2'd2) begin failures++; $display("FAIL refill_rrpv got=%0d exp=2", bus.ins_rrpv_o); end
    @(negedge clk);
  endtask

  task automatic test_cold_evict();
    start_fill(5, 2, 64'h0000_2000); bus.pred_result_i = 2'd1;
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_miss_o !== 1'b1) begin failures++; $display("FAIL cold_miss got=%b exp=1", bus.pred_miss_o); end
    checks++; if (bus.pred_outcome_o !== 1'b0) begin failures++; $display("FAIL cold_outcome got=%b exp=0", bus.pred_outcome_o); end
    checks++; if (bus.pred_miss_shct_o !== 14'h0001) begin failures++; $display("FAIL cold_miss_shct got=%h exp=0001", bus.pred_miss_shct_o); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back_collision();
    do_fill(1, 0, 64'h0000_1234);
    do_fill(2, 0, 64'h0000_1234);
    @(negedge clk); start_fill(2, 0, 64'h0000_0004); start_hit(1, 0);
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_miss_o !== 1'b1) begin failures++; $display("FAIL coll_miss got=%b exp=1", bus.pred_miss_o); end
    checks++; if (bus.pred_hit_o !== 1'b0) begin failures++; $display("FAIL coll_hit_withheld got=%b exp=0", bus.pred_hit_o); end
    checks++; if (bus.pred_miss_shct_o !== 14'h048D) begin failures++; $display("FAIL coll_miss_shct got=%h exp=048d", bus.pred_miss_shct_o); end
    checks++; if (bus.acc_ready_o !== 1'b1) begin failures++; $display("FAIL coll_ready_before got=%b exp=1", bus.acc_ready_o); end
    @(negedge clk); #1;
    checks++; if (bus.pred_hit_o !== 1'b1) begin failures++; $display("FAIL coll_hit_deferred got=%b exp=1", bus.pred_hit_o); end
    checks++; if (bus.pred_hit_shct_o !== 14'h048D) begin failures++; $display("FAIL coll_hit_shct got=%h exp=048d", bus.pred_hit_shct_o); end
    checks++; if (bus.acc_ready_o !== 1'b0) begin failures++; $display("FAIL coll_ready_low got=%b exp=0", bus.acc_ready_o); end
    @(negedge clk); #1;
    checks++; if (bus.acc_ready_o !== 1'b1) begin failures++; $display("FAIL coll_ready_back got=%b exp=1", bus.acc_ready_o); end
    checks++; if (bus.pred_hit_o !== 1'b0) begin failures++; $display("FAIL coll_hit_once got=%b exp=0", bus.pred_hit_o); end
  endtask

  task automatic test_forward();
    @(negedge clk); start_fill(2, 0, 64'h0000_0008);
    @(negedge clk); drive_idle(); start_hit(2, 0); #1;
    checks++; if (bus.pred_outcome_o !== 1'b1) begin failures++; $display("FAIL fwd_outcome got=%b exp=1", bus.pred_outcome_o); end
    checks++; if (bus.pred_miss_shct_o !== 14'h0001) begin failures++; $display("FAIL fwd_miss_shct got=%h exp=0001", bus.pred_miss_shct_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_hit_o !== 1'b1) begin failures++; $display("FAIL fwd_hit_pulse got=%b exp=1", bus.pred_hit_o); end
    checks++; if (bus.pred_hit_shct_o !== 14'h0001) begin failures++; $display("FAIL fwd_hit_shct got=%h exp=0001", bus.pred_hit_shct_o); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    do_fill(7, 1, 64'h0000_1234);
    @(negedge clk); start_fill(7, 1, 64'h0000_0008);
    @(negedge clk); drive_idle(); bus.flush_i = 1'b1; #1;
    checks++; if (bus.pred_miss_o !== 1'b0) begin failures++; $display("FAIL flush_miss_suppressed got=%b exp=0", bus.pred_miss_o); end
    @(negedge clk); bus.flush_i = 1'b0; #1;
    checks++; if (bus.ins_valid_o !== 1'b0) begin failures++; $display("FAIL flush_no_ins got=%b exp=0", bus.ins_valid_o); end
    checks++; if (bus.fill_ready_o !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b exp=1", bus.fill_ready_o); end
    start_hit(7, 1);
    @(negedge clk); drive_idle(); #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin failures++; $display("FAIL flush_line_invalid got=%b exp=0", bus.pred_hit_o); end
  endtask

  task automatic test_reset_midfill();
    @(negedge clk); start_fill(3, 0, 64'h0000_1234);
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus.fill_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_idle got=%b exp=1", bus.fill_ready_o); end
    checks++; if (bus.ins_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ins got=%b exp=0", bus.ins_valid_o); end
    checks++; if (bus.pred_shct_o !== 14'h0) begin failures++; $display("FAIL rst_mid_shct got=%h exp=0000", bus.pred_shct_o); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_fill();
    test_hit();
    test_refill();
    test_cold_evict();
    test_back_to_back_collision();
    test_forward();
    test_flush();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wt_dcache_ship_tracker.md
# wt_dcache_ship_tracker

Per-line signature and outcome tracker for the write-through L1 dcache's SHiP replacement. It observes cache hits and fills, keeps a 14-bit PC signature plus a re-reference outcome bit per line, and produces the hit and miss training pulses consumed by the SHCT predictor. On every fill it queries the predictor and returns the RRPV insertion value to the replacement logic.

## Interface
- NumSets, 256, dcache sets (power of two)
- NumWays, 8, dcache ways (power of two)
- SigWidth, 14, signature width; must match the SHCT index width
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high; one clock, all state on clk_i rising edge
- flush_i  in  1  cache flush; invalidates all tracked lines
- acc_valid_i / acc_ready_o  in/out  1  access-event handshake
- acc_hit_i  in  1  access hit a valid line
- acc_set_i / acc_way_i  in  log2(NumSets) / log2(NumWays)  accessed line
- fill_valid_i / fill_ready_o  in/out  1  fill-event handshake
- fill_set_i / fill_way_i  in  log2(NumSets) / log2(NumWays)  line being filled
- fill_pc_i  in  64  PC of the missing load
- ins_valid_o  out  1  one-cycle insertion-result strobe
- ins_rrpv_o  out  2  insertion RRPV
- pred_hit_o, pred_miss_o, pred_outcome_o  out  1  predictor training controls
- pred_hit_shct_o, pred_miss_shct_o, pred_shct_o  out  SigWidth  predictor indices
- pred_result_i  in  2  SHCT counter at pred_shct_o (combinational)

## Operation
- Signature: sig = fill_pc_i[15:2] XOR fill_pc_i[29:16] (SigWidth bits).
- Per-line metadata: valid, sig, outcome. Reset and flush clear every valid bit and outcome bit.
- Hit path: an accepted access with acc_hit_i=1 to a valid line is registered. In the next cycle, pred_hit_o=1 and pred_hit_shct_o=stored sig. The line's outcome bit is set at the acceptance edge. Misses and hits to invalid lines are ignored.
- Fill FSM has three states.
  - IDLE: fill_ready_o=1. An accepted fill goes to EVICT.
  - EVICT: if the victim line is valid, pred_miss_o=1, pred_miss_shct_o=victim sig, and pred_outcome_o=victim outcome. pred_shct_o=new sig. pred_result_i is registered. Next state is INSERT.
  - INSERT: ins_valid_o=1. ins_rrpv_o=3 if the registered result is 0, else 2. Line metadata is written as valid=1, sig=new, outcome=0. Next state is IDLE.
- Predictor aliasing rules (mandatory, because the SHCT's idle path rewrites old values):
  - When pred_miss_o=0, drive pred_miss_shct_o = pred_hit_shct_o XOR 1.
  - When pred_hit_o=0, drive pred_hit_shct_o = pred_miss_shct_o XOR 1.
  - When both are asserted with equal signatures, withhold the hit. It moves to a one-entry skid and issues the next cycle.
- acc_ready_o=0 while the skid is full. The skid has priority over newly registered hits.
- A hit to the victim line in the EVICT cycle is forwarded: pred_outcome_o=1.
- flush_i forces the FSM to IDLE, drops the pending hit and skid, and suppresses all pred_* and ins_valid_o that cycle. A fill in progress is abandoned with no insertion strobe.

## Timing
- Reset values:
  - pred_hit_o, pred_miss_o, pred_outcome_o, ins_valid_o = 0
  - ins_rrpv_o = 0
  - pred_shct_o = 0
  - fill_ready_o = 1
  - acc_ready_o = 1
- Hit-to-training latency is 1 cycle, or 2 cycles if deferred by the skid.
- Fill acceptance to ins_valid_o is 2 cycles. Fill throughput is one per 3 cycles.
- Reset asserted mid-fill returns the FSM to IDLE on the next edge.

## Structure
- wt_cache_pkg gains:
  - ship_sig_t (logic [SigWidth-1:0])
  - SHIP_RRPV_DISTANT=2'd3 and SHIP_RRPV_LONG=2'd2
  - function ship_sig(pc)
- Sub-module wt_dcache_ship_meta holds the NumSets×NumWays metadata flop array. It has one write port for fill/outcome writes, one read port for access, and one read port for the victim.

## Test plan
- Reset, then fill set 5 way 2 with pc=0x0000_1234 and pred_result_i=0 → no pred_miss_o; ins_valid_o two cycles later with ins_rrpv_o=3; stored sig=0x048D.
- Hit set 5 way 2 → next cycle pred_hit_o=1, pred_hit_shct_o=0x048D, pred_miss_shct_o=0x048C.
- Refill set 5 way 2 with pred_result_i=2 → in EVICT, pred_miss_o=1, pred_outcome_o=1, sig 0x048D; ins_rrpv_o=2.
- Hit and miss pulses in the same cycle with equal signatures → pred_miss_o in that cycle, pred_hit_o one cycle later, and acc_ready_o low for that one cycle.
- Fill a line, evict it without any hit → pred_outcome_o=0.
- flush_i in the EVICT cycle → no ins_valid_o; a subsequent hit to that line produces no pred_hit_o.
